// File: rtl/tt_sequencer.sv
// -----------------------------------------------------------------------------
// tt_sequencer
//
// Truth-table stimulus and checker for 3-input combinational function blocks.
// Walks {A,B,C} through vectors 000..111. Each vector is held for SETTLE_CYC
// cycles, then the block's Y is captured in a one-cycle SAMPLE window and
// compared against the expected column. Failing vectors, an error count and a
// pass flag are reported when the run completes.
//
// Parameters:
//   EXPECTED   - expected Y column, bit i = expected Y for vector i = {A,B,C}
//   SETTLE_CYC - cycles between applying a vector and sampling Y (1..15)
//
// Ports:
//   i_clk         - clock, rising edge
//   i_rst_n       - synchronous active-low reset
//   i_start       - begin a run (honoured in IDLE or DONE only)
//   i_dut_y       - Y output of the block under test
//   o_a/o_b/o_c   - block inputs A (MSB), B, C (LSB), i.e. the vector index
//   o_busy        - run in progress (SETTLE or SAMPLE)
//   o_done        - run finished; held until the next start or reset
//   o_pass        - valid with o_done; 1 when no vector mismatched
//   o_err_count   - number of mismatching vectors (0..8)
//   o_fail_vec    - bit i set when vector i mismatched
//   o_dbg_state   - current FSM state (0 IDLE, 1 SETTLE, 2 SAMPLE, 3 DONE)
//
// Configuration macro:
//   TT_STOP_ON_FAIL_EN - when defined, the first mismatch ends the run with
//                        {A,B,C} holding the failing vector.
//
// Handshake: none with the block under test. Its Y must settle within
// SETTLE_CYC cycles of a new vector; Y is captured at the closing edge of the
// SAMPLE cycle.
// -----------------------------------------------------------------------------
module tt_sequencer #(
    parameter logic [7:0] EXPECTED   = 8'b1110_0100,
    parameter int         SETTLE_CYC = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_dut_y,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_count,
    output logic [7:0] o_fail_vec,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE_CYC - 1);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [3:0] r_err_count;
    logic [7:0] r_fail_vec;
    logic       r_busy;
    logic       r_done;

    logic       w_mismatch;

    assign w_mismatch = (i_dut_y != EXPECTED[r_idx]);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_cnt       <= 4'd0;
            r_err_count <= 4'd0;
            r_fail_vec  <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                // DONE behaves like IDLE for start; results are held otherwise.
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state     <= ST_SETTLE;
                        r_idx       <= 3'd0;
                        r_cnt       <= 4'd0;
                        r_err_count <= 4'd0;
                        r_fail_vec  <= 8'd0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end

                ST_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LP_CNT_LAST) begin
                        r_state <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        r_fail_vec[r_idx] <= 1'b1;
                        r_err_count       <= r_err_count + 4'd1;
                    end
`ifdef TT_STOP_ON_FAIL_EN
                    if (w_mismatch || r_idx == 3'd7) begin
`else
                    if (r_idx == 3'd7) begin
`endif
                        // r_idx is left alone so {a,b,c} keeps the last vector.
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_SETTLE;
                        r_idx   <= r_idx + 3'd1;
                        r_cnt   <= 4'd0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign {o_a, o_b, o_c} = r_idx;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_done && (r_err_count == 4'd0);
    assign o_err_count     = r_err_count;
    assign o_fail_vec      = r_fail_vec;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_tt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tt_sequencer
//
// Three sequencer instances with different expected columns and settle times
// (2, 1, 15). Each drives its own behavioural function block whose Y is the
// instance's expected column XOR a per-run bad-vector mask, optionally
// inverted during the settle part of each vector window so that a capture
// outside the SAMPLE cycle would be visible.
//
// Timeline reference: start sampled at edge 0; vector v occupies cycles
// v*(S+1) .. v*(S+1)+S; the run ends at edge (last+1)*(S+1).
// -----------------------------------------------------------------------------
module tb_tt_sequencer;

    localparam int N = 3;
    localparam int SC [N] = '{2, 1, 15};
    localparam logic [N-1:0][7:0] EXP = {8'h3C, 8'h96, 8'hE4};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // ---------------- DUT signals ----------------
    logic [N-1:0]      start;
    logic [N-1:0]      y;
    logic [N-1:0]      a, b, c, busy, done, pass;
    logic [N-1:0][3:0] err;
    logic [N-1:0][7:0] fvec;
    logic [N-1:0][1:0] st;

    logic [7:0] bad_mask;
    logic       noise;

    int n_tests;
    int n_fail;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [2:0] w_v;
        assign w_v  = {a[g], b[g], c[g]};
        // Behavioural function block: correct column, corrupted where asked.
        assign y[g] = EXP[g][w_v] ^ bad_mask[w_v] ^ noise;

        tt_sequencer #(
            .EXPECTED  (EXP[g]),
            .SETTLE_CYC(SC[g])
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_start     (start[g]),
            .i_dut_y     (y[g]),
            .o_a         (a[g]),
            .o_b         (b[g]),
            .o_c         (c[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g]),
            .o_pass      (pass[g]),
            .o_err_count (err[g]),
            .o_fail_vec  (fvec[g]),
            .o_dbg_state (st[g])
        );
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cleared(input int g, input string tag);
        check({tag, "_abc"},   {29'd0, a[g], b[g], c[g]}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy[g]}, 32'd0);
        check({tag, "_done"},  {31'd0, done[g]}, 32'd0);
        check({tag, "_pass"},  {31'd0, pass[g]}, 32'd0);
        check({tag, "_err"},   {28'd0, err[g]}, 32'd0);
        check({tag, "_fvec"},  {24'd0, fvec[g]}, 32'd0);
        check({tag, "_state"}, {30'd0, st[g]}, 32'd0);
    endtask

    // ---------------- driver + scoreboard ----------------
    // g: instance; bad: vectors whose Y is wrong; poke7: pulse start at cycle 7;
    // use_noise: invert Y outside the SAMPLE cycle; abort_at: cycle at which to
    // assert reset (-1 = never).
    task automatic run(input int g, input logic [7:0] bad, input bit poke7,
                       input bit use_noise, input int abort_at);
        int         s;
        int         last;
        int         total;
        int         nerr;
        logic [7:0] efail;
        logic [2:0] v;
        logic [2:0] exp_q[$];

        s = SC[g];
`ifdef TT_STOP_ON_FAIL_EN
        last = 7;
        for (int i = 7; i >= 0; i--) if (bad[i]) last = i;
        efail = (bad == 8'd0) ? 8'd0 : (8'd1 << last);
`else
        last  = 7;
        efail = bad;
`endif
        nerr  = $countones(efail);
        total = (last + 1) * (s + 1);
        for (int vi = 0; vi <= last; vi++)
            for (int r = 0; r <= s; r++) exp_q.push_back(3'(vi));

        bad_mask = bad;
        noise    = 1'b0;
        @(negedge clk);
        start[g] = 1'b1;
        @(posedge clk);
        #1;
        start[g] = 1'b0;

        for (int k = 0; k < total; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                noise = 1'b0;
                @(posedge clk);
                #1;
                check_cleared(g, "reset_mid");
                rst_n = 1'b1;
                return;
            end
            noise = use_noise && ((k % (s + 1)) != s);
            v = exp_q.pop_front();
            check("run_abc",  {29'd0, a[g], b[g], c[g]}, {29'd0, v});
            check("run_busy", {31'd0, busy[g]}, 32'd1);
            check("run_done", {31'd0, done[g]}, 32'd0);
            check("run_pass", {31'd0, pass[g]}, 32'd0);
            if (k == 0) begin
                check("start_err_clear",  {28'd0, err[g]}, 32'd0);
                check("start_fvec_clear", {24'd0, fvec[g]}, 32'd0);
            end
            start[g] = poke7 && (k == 7);
            @(posedge clk);
            #1;
            start[g] = 1'b0;
        end

        noise = 1'b0;
        check("end_done", {31'd0, done[g]}, 32'd1);
        check("end_busy", {31'd0, busy[g]}, 32'd0);
        check("end_pass", {31'd0, pass[g]}, {31'd0, nerr == 0});
        check("end_err",  {28'd0, err[g]}, 32'(nerr));
        check("end_fvec", {24'd0, fvec[g]}, {24'd0, efail});
        check("end_abc",  {29'd0, a[g], b[g], c[g]}, 32'(last));
        repeat (2) @(posedge clk);
        #1;
        check("hold_done", {31'd0, done[g]}, 32'd1);
        check("hold_fvec", {24'd0, fvec[g]}, {24'd0, efail});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = '1;   // start is ignored during reset
        bad_mask = 8'd0;
        noise    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) check_cleared(g, "reset");
        start = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(0, 8'h00, 1'b0, 1'b0, -1);   // matching block
        run(0, 8'hFF, 1'b0, 1'b0, -1);   // inverted block, rerun from DONE
        run(0, 8'h20, 1'b0, 1'b0, -1);   // single bad vector 101
        run(1, 8'h00, 1'b0, 1'b1, -1);   // SETTLE_CYC=1, noisy settle
        run(2, 8'h00, 1'b0, 1'b1, -1);   // SETTLE_CYC=15, noisy settle
        run(1, 8'h20, 1'b0, 1'b1, -1);
        run(0, 8'h00, 1'b1, 1'b1, -1);   // start while busy ignored
        run(0, 8'h11, 1'b0, 1'b0, 10);   // reset mid-run at idx 3
        run(0, 8'h00, 1'b0, 1'b0, -1);   // clean pass after reset

        repeat (8) begin
            run(int'($urandom_range(0, N - 1)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
